// File: rtl/reg_bus_arbiter_if.sv
// Register-file arbiter bus: SPI front-end, internal requester and
// register-file port bundled together. The arbiter takes the slave view;
// the surrounding logic (or a bench) takes the master view.
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  // SPI front-end
  logic [ADDR_W-1:0] spi_addr;
  logic [REG_W-1:0]  spi_wdata;
  logic              spi_wr_dv;
  logic              spi_rd_req;
  logic [REG_W-1:0]  spi_rdata;
  logic              spi_rdata_dv;
  logic              spi_wr_ovf;

  // Internal requester
  logic              int_req;
  logic              int_we;
  logic [ADDR_W-1:0] int_addr;
  logic [REG_W-1:0]  int_wdata;
  logic              int_ack;
  logic [REG_W-1:0]  int_rdata;

  // Register file port
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_we;
  logic              rf_re;
  logic [REG_W-1:0]  rf_wdata;
  logic [REG_W-1:0]  rf_rdata;

  modport slave (
    input  spi_addr, spi_wdata, spi_wr_dv, spi_rd_req,
    input  int_req, int_we, int_addr, int_wdata,
    input  rf_rdata,
    output spi_rdata, spi_rdata_dv, spi_wr_ovf,
    output int_ack, int_rdata,
    output rf_addr, rf_we, rf_re, rf_wdata
  );

  modport master (
    output spi_addr, spi_wdata, spi_wr_dv, spi_rd_req,
    output int_req, int_we, int_addr, int_wdata,
    output rf_rdata,
    input  spi_rdata, spi_rdata_dv, spi_wr_ovf,
    input  int_ack, int_rdata,
    input  rf_addr, rf_we, rf_re, rf_wdata
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one single-ported register file between the SPI
// register front-end (buffered write strobes, level read requests) and one
// internal req/ack requester. A round-robin FSM issues one access at a time:
// writes take 2 cycles (grant, issue), reads take 3 (grant, issue, data).
module reg_bus_arbiter #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input logic              clk,
  input logic              rstb,
  input logic              ena,
  reg_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  localparam logic SRC_SPI = 1'b0;
  localparam logic SRC_INT = 1'b1;

  // FSM state and the registered grant context
  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              op_we_reg, op_we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              last_grant_reg, last_grant_next;

  // SPI write buffer (single entry, latest wins)
  logic              wr_pend_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [REG_W-1:0]  wr_data_reg;
  logic              wr_ovf_reg;

  // Decoded requests and strobes
  logic              active;
  logic              spi_wr_any;
  logic              spi_want;
  logic              int_want;
  logic              wr_issue;

  logic [ADDR_W-1:0] rf_addr;
  logic [REG_W-1:0]  rf_wdata;
  logic              rf_we;
  logic              rf_re;
  logic [REG_W-1:0]  spi_rdata;
  logic              spi_rdata_dv;
  logic [REG_W-1:0]  int_rdata;
  logic              int_ack;

  // Request decode. A write strobe arriving this cycle already counts as a
  // pending write, so a lone SPI write reaches rf_we one cycle after its
  // strobe. Strobes are suppressed while disabled or while reset is applied,
  // so an access interrupted by reset never emits ack/dv.
  always_comb begin
    active     = ena & rstb;
    spi_wr_any = wr_pend_reg | bus.spi_wr_dv;
    spi_want   = spi_wr_any | bus.spi_rd_req;
    int_want   = bus.int_req;
  end

  // FSM state register and grant context; everything holds while ena=0.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg      <= IDLE;
      grant_reg      <= SRC_SPI;
      op_we_reg      <= 1'b0;
      addr_reg       <= '0;
      last_grant_reg <= SRC_INT;
    end else if (ena) begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      op_we_reg      <= op_we_next;
      addr_reg       <= addr_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Next-state, arbitration and register-file / requester strobes.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    op_we_next      = op_we_reg;
    addr_next       = addr_reg;
    last_grant_next = last_grant_reg;
    rf_addr         = '0;
    rf_wdata        = '0;
    rf_we           = 1'b0;
    rf_re           = 1'b0;
    spi_rdata       = '0;
    spi_rdata_dv    = 1'b0;
    int_rdata       = '0;
    int_ack         = 1'b0;
    wr_issue        = 1'b0;

    if (active) begin
      case (state_reg)
        IDLE: begin
          // Round robin: on a tie the port not granted last wins.
          if (spi_want && (!int_want || last_grant_reg == SRC_INT)) begin
            grant_next      = SRC_SPI;
            op_we_next      = spi_wr_any;
            addr_next       = bus.spi_addr;
            last_grant_next = SRC_SPI;
            state_next      = ISSUE;
          end else if (int_want) begin
            grant_next      = SRC_INT;
            op_we_next      = bus.int_we;
            addr_next       = bus.int_addr;
            last_grant_next = SRC_INT;
            state_next      = ISSUE;
          end
        end

        ISSUE: begin
          if (op_we_reg) begin
            rf_we = 1'b1;
            if (grant_reg == SRC_SPI) begin
              // SPI writes come from the buffer so address and data always
              // belong to the same (latest) strobe, even if it was
              // overwritten in the grant cycle.
              rf_addr  = wr_addr_reg;
              rf_wdata = wr_data_reg;
              wr_issue = 1'b1;
            end else begin
              // The internal requester holds its write data until ack.
              rf_addr  = addr_reg;
              rf_wdata = bus.int_wdata;
              int_ack  = 1'b1;
            end
            state_next = IDLE;
          end else begin
            rf_re      = 1'b1;
            rf_addr    = addr_reg;
            state_next = RDATA;
          end
        end

        RDATA: begin
          if (grant_reg == SRC_SPI) begin
            spi_rdata_dv = 1'b1;
            spi_rdata    = bus.rf_rdata;
          end else begin
            int_ack   = 1'b1;
            int_rdata = bus.rf_rdata;
          end
          state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // SPI write buffer: capture every strobe, clear on issue, flag overwrite
  // of an entry that was never issued. A strobe landing on the issue cycle
  // refills the buffer without counting as an overflow.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_pend_reg <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_ovf_reg  <= 1'b0;
    end else if (ena) begin
      if (bus.spi_wr_dv) begin
        wr_addr_reg <= bus.spi_addr;
        wr_data_reg <= bus.spi_wdata;
        wr_pend_reg <= 1'b1;
        if (wr_pend_reg && !wr_issue) begin
          wr_ovf_reg <= 1'b1;
        end
      end else if (wr_issue) begin
        wr_pend_reg <= 1'b0;
      end
    end
  end

  assign bus.rf_addr      = rf_addr;
  assign bus.rf_wdata     = rf_wdata;
  assign bus.rf_we        = rf_we;
  assign bus.rf_re        = rf_re;
  assign bus.spi_rdata    = spi_rdata;
  assign bus.spi_rdata_dv = spi_rdata_dv;
  assign bus.spi_wr_ovf   = wr_ovf_reg;
  assign bus.int_rdata    = int_rdata;
  assign bus.int_ack      = int_ack;

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Shares a single-ported register file between the SPI register front-end and one internal requester, such as the synth sequencer updating registers. SPI writes arrive as one-cycle data-valid pulses and are buffered so none is lost. SPI reads are a level request held until answered. The internal port uses a req/ack handshake. A round-robin FSM issues one register-file access at a time.

## Interface
Parameters:
- ADDR_W, 3, register address width
- REG_W, 8, register data width

Ports:
- clk  in  1  clock
- rstb  in  1  reset, synchronous, active-low
- ena  in  1  global enable; 0 freezes all state
- spi_addr  in  ADDR_W  SPI transaction address
- spi_wdata  in  REG_W  SPI write data
- spi_wr_dv  in  1  one-cycle SPI write strobe
- spi_rd_req  in  1  SPI read request, level, held until spi_rdata_dv
- spi_rdata  out  REG_W  read data, valid only while spi_rdata_dv=1
- spi_rdata_dv  out  1  one-cycle read-data-valid pulse
- spi_wr_ovf  out  1  sticky: an SPI write overwrote an unissued pending write
- int_req  in  1  internal request; int_we/int_addr/int_wdata stable until int_ack
- int_we  in  1  1=write, 0=read
- int_addr  in  ADDR_W  internal address
- int_wdata  in  REG_W  internal write data
- int_ack  out  1  one-cycle completion pulse
- int_rdata  out  REG_W  read data, valid only while int_ack=1 on a read
- rf_addr  out  ADDR_W  register-file address
- rf_we  out  1  register-file write strobe
- rf_re  out  1  register-file read strobe
- rf_wdata  out  REG_W  register-file write data
- rf_rdata  in  REG_W  read data, valid the cycle after rf_re

## Operation
- SPI write buffer:
  - spi_wr_dv=1 loads {spi_addr, spi_wdata} into the buffer and sets spi_wr_pend.
  - spi_wr_pend clears when the buffered write is issued.
  - If spi_wr_dv arrives while spi_wr_pend=1 and the buffer is not issuing that cycle: overwrite the buffer (latest wins) and set spi_wr_ovf.
  - If spi_wr_dv coincides with issue of the buffered write: the old entry issues, the new entry is captured, spi_wr_pend stays 1, and spi_wr_ovf is not set.
- Request lines:
  - SPI request = spi_wr_pend | spi_rd_req. Within the SPI port, a pending write goes before a read.
  - Internal request = int_req.
- FSM states: IDLE, ISSUE, RDATA.
  - IDLE: if no request, stay. If one port requests, grant it. If both request, grant the port not granted last (last_grant flips on each grant). Register grant, op and address, then go to ISSUE.
  - ISSUE: drive rf_addr from the granted source.
    - Write: rf_we=1 and rf_wdata driven from the granted source. For a SPI grant, clear spi_wr_pend; for an internal grant, pulse int_ack. Go to IDLE.
    - Read: rf_re=1, go to RDATA.
  - RDATA: for a SPI grant, spi_rdata_dv=1 and spi_rdata=rf_rdata. For an internal grant, int_ack=1 and int_rdata=rf_rdata. Go to IDLE.
- Idle strobes: rf_we, rf_re, int_ack and spi_rdata_dv are 0 outside the cases above. rf_addr and rf_wdata are don't-care when no strobe is active.
- Re-request rules:
  - The requester must drop int_req, or present a new request, in the cycle after int_ack.
  - spi_rd_req falls in the cycle after spi_rdata_dv. Because the FSM spends that cycle in IDLE, a read is never served twice.
- ena=0: FSM, buffer, last_grant and ovf hold; all strobes forced 0. When ena returns to 1, operation resumes from the held state.

## Timing
- Reset (rstb=0 at a clk edge) gives:
  - state=IDLE, spi_wr_pend=0, spi_wr_ovf=0.
  - last_grant=internal, so SPI wins the first tie.
  - All strobes 0; spi_rdata, int_rdata and rf_* are 0.
- Reset mid-operation aborts the access. A pending write is dropped, and no ack or dv is emitted for it.
- Latency from a request sampled in IDLE:
  - Write: rf_we at +1 cycle; 2 cycles per write.
  - Read: rf_re at +1 and data/ack at +2; 3 cycles per read.
- Worst-case SPI wait under continuous internal traffic is one internal access, at most 3 cycles. This is far below the SPI frame time, so spi_wr_ovf indicates a system fault.
- Widths: all addresses and data pass through unmodified; no arithmetic.

## Test plan
- SPI write: spi_wr_dv with addr=5, wdata=0xA7 -> rf_we=1 with rf_addr=5, rf_wdata=0xA7 exactly 1 cycle later; spi_wr_pend clears; no int_ack.
- SPI read: rf holds 0x3C at addr 2; spi_rd_req held with addr=2 -> rf_re at +1, spi_rdata_dv=1 with spi_rdata=0x3C at +2; exactly one dv pulse after spi_rd_req drops.
- Contention: int_req (write addr 1, 0x11) and spi_wr_dv (addr 1, 0x22) in the same cycle after reset -> SPI issues first, then internal; final rf[1]=0x11. Repeated ties alternate grants.
- Overflow: hold int_req reads continuously and pulse spi_wr_dv twice, 1 cycle apart, while pending -> spi_wr_ovf=1 and only the second value is written; spi_wr_ovf stays 1 until rstb=0.
- ena gating: drop ena during ISSUE of an internal read for 4 cycles -> no rf_re while ena=0; rf_re then int_ack follow once ena=1, with correct int_rdata.
- Reset during RDATA: assert rstb=0 -> no spi_rdata_dv/int_ack; state IDLE, pend=0, ovf=0 next cycle.
